exe_wb_pipe: RTL and testbench

Parametrised execute-to-writeback result pipeline. It replaces the fixed three-entry regfile write buffer with a `DEPTH`-stage shift pipeline and adds stall, selective flush, and multi-port operand forwarding. It sits between the ALU result and the register file write port. The decode/execute operand muxes query it so that results still in flight reach dependent instructions.

---
 rtl/exe_wb_pipe.sv | 118 +++++++++++
 tb/tb_exe_wb_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_wb_pipe.sv
// Execute-to-writeback result pipeline: DEPTH-stage shift register feeding the
// regfile write port, with stall, selective flush and NREAD forwarding ports.
// Define EXE_WB_PIPE_BYPASS_EN to also forward the incoming result in the same cycle.
module exe_wb_pipe #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 3,
  parameter int NREAD        = 2,
  parameter int FLUSH_STAGES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         in_we,
  input  logic [4:0]                   in_rd_a,
  input  logic [XLEN-1:0]              in_rd_d,
  input  logic [NREAD*5-1:0]           q_rs_a,
  output logic [NREAD-1:0]             q_hit,
  output logic [NREAD*XLEN-1:0]        q_d,
  output logic                         rf_rd_e,
  output logic [4:0]                   rf_rd_a,
  output logic [XLEN-1:0]              rf_rd_i,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OCCW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       a_q [DEPTH];
  logic [4:0]       a_d [DEPTH];
  logic [XLEN-1:0]  d_q [DEPTH];
  logic [XLEN-1:0]  d_d [DEPTH];

  logic             cap_s;
  logic [4:0]       rs_s;
  logic             hit_s;
  logic             m_s;
  logic [XLEN-1:0]  dat_s;
  logic [OCCW-1:0]  occ_s;

  // Next-state: hold on stall, otherwise shift toward the tail; flush clears the youngest stages last.
  always_comb begin
    cap_s = in_we & (in_rd_a != 5'd0) & ~stall & ~flush;
    vld_d = vld_q;
    a_d   = a_q;
    d_d   = d_q;
    if (stall) begin
      vld_d = vld_q;
    end else begin
      for (int s = DEPTH - 1; s >= 1; s--) begin
        vld_d[s] = vld_q[s-1];
        a_d[s]   = a_q[s-1];
        d_d[s]   = d_q[s-1];
      end
      vld_d[0] = cap_s;
      a_d[0]   = in_rd_a;
      d_d[0]   = in_rd_d;
    end
    for (int s = 0; s < DEPTH; s++) begin
      vld_d[s] = vld_d[s] & ~(flush & (s < FLUSH_STAGES));
    end
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        a_q[s] <= 5'd0;
        d_q[s] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      d_q   <= d_d;
    end
  end

  // Forwarding lookup: scanning tail-to-head lets the youngest match win.
  always_comb begin
    q_hit = '0;
    q_d   = '0;
    rs_s  = 5'd0;
    hit_s = 1'b0;
    m_s   = 1'b0;
    dat_s = '0;
    for (int i = 0; i < NREAD; i++) begin
      rs_s  = q_rs_a[5*i +: 5];
      hit_s = 1'b0;
      dat_s = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
        m_s   = vld_q[s] & (a_q[s] == rs_s) & (rs_s != 5'd0);
        hit_s = hit_s | m_s;
        dat_s = m_s ? d_q[s] : dat_s;
      end
`ifdef EXE_WB_PIPE_BYPASS_EN
      m_s   = in_we & (in_rd_a != 5'd0) & ~flush & (in_rd_a == rs_s);
      hit_s = hit_s | m_s;
      dat_s = m_s ? in_rd_d : dat_s;
`endif
      q_hit[i]           = hit_s;
      q_d[XLEN*i +: XLEN] = dat_s;
    end
  end

  // Regfile write port and occupancy, straight from the stage registers.
  always_comb begin
    rf_rd_e = vld_q[DEPTH-1] & ~stall;
    rf_rd_a = a_q[DEPTH-1];
    rf_rd_i = d_q[DEPTH-1];
    occ_s   = '0;
    for (int s = 0; s < DEPTH; s++) begin
      occ_s = occ_s + OCCW'(vld_q[s]);
    end
    occ = occ_s;
  end

endmodule

// File: tb/tb_exe_wb_pipe.sv
// Bench for exe_wb_pipe: directed scenarios plus random traffic, checked against
// an age-tracking list of in-flight results.
module tb_exe_wb_pipe;
  localparam int XLEN  = 32;
  localparam int DEPTH = 3;
  localparam int NREAD = 2;
  localparam int FS    = 1;

  logic              clk = 1'b0;
  logic              rst, stall, flush, in_we;
  logic [4:0]        in_rd_a;
  logic [XLEN-1:0]   in_rd_d;
  logic [NREAD*5-1:0] q_rs_a;
  logic [NREAD-1:0]  q_hit;
  logic [NREAD*XLEN-1:0] q_d;
  logic              rf_rd_e;
  logic [4:0]        rf_rd_a;
  logic [XLEN-1:0]   rf_rd_i;
  logic [1:0]        occ;

  always #5 clk = ~clk;

  exe_wb_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .FLUSH_STAGES(FS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_we(in_we),
    .in_rd_a(in_rd_a), .in_rd_d(in_rd_d), .q_rs_a(q_rs_a), .q_hit(q_hit),
    .q_d(q_d), .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i), .occ(occ)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] dat;
    int          age;   // edges survived since capture; retires on the edge after age==DEPTH
  } ent_t;

  ent_t mq[$];
  int total = 0;
  int bad   = 0;
  int writes = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic f, input logic we,
                            input logic [4:0] rd, input logic [31:0] dat);
    ent_t nq[$];
    ent_t e;
    if (r) begin
      mq.delete();
    end else begin
      if (!s) begin
        foreach (mq[k]) if (mq[k].age < DEPTH) begin
          e = mq[k];
          e.age++;
          nq.push_back(e);
        end
        if (we && rd != 5'd0 && !f) begin
          e.rd = rd; e.dat = dat; e.age = 1;
          nq.push_back(e);
        end
      end else begin
        nq = mq;
      end
      mq.delete();
      foreach (nq[k]) if (!(f && nq[k].age <= FS)) mq.push_back(nq[k]);
    end
  endtask

  function automatic void exp_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    int best = DEPTH + 1;
    hit = 1'b0;
    d   = 32'd0;
    foreach (mq[k]) if (rs != 5'd0 && mq[k].rd == rs && mq[k].age < best) begin
      best = mq[k].age; hit = 1'b1; d = mq[k].dat;
    end
`ifdef EXE_WB_PIPE_BYPASS_EN
    if (in_we && in_rd_a != 5'd0 && !flush && in_rd_a == rs) begin
      hit = 1'b1; d = in_rd_d;
    end
`endif
  endfunction

  // One clock: drive, check outputs against the model, take the edge, advance the model.
  task automatic step(input logic r, input logic s, input logic f, input logic we,
                      input logic [4:0] rd, input logic [31:0] dat,
                      input logic [4:0] q0, input logic [4:0] q1);
    logic eh;
    logic [31:0] ed;
    logic te;
    logic [4:0] ta;
    logic [31:0] ti;
    rst = r; stall = s; flush = f; in_we = we; in_rd_a = rd; in_rd_d = dat;
    q_rs_a = {q1, q0};
    #1;
    if (!r) begin
      te = 1'b0; ta = 5'd0; ti = 32'd0;
      foreach (mq[k]) if (mq[k].age == DEPTH) begin
        te = !s; ta = mq[k].rd; ti = mq[k].dat;
      end
      check_val("rf_e", 64'(rf_rd_e), 64'(te));
      if (te) begin
        check_val("rf_a", 64'(rf_rd_a), 64'(ta));
        check_val("rf_i", 64'(rf_rd_i), 64'(ti));
      end
      check_val("occ", 64'(occ), 64'(mq.size()));
      exp_fwd(q0, eh, ed);
      check_val("hit0", 64'(q_hit[0]), 64'(eh));
      check_val("qd0", 64'(q_d[31:0]), 64'(ed));
      exp_fwd(q1, eh, ed);
      check_val("hit1", 64'(q_hit[1]), 64'(eh));
      check_val("qd1", 64'(q_d[63:32]), 64'(ed));
      if (rf_rd_e) writes++;
    end
    @(posedge clk);
    model_edge(r, s, f, we, rd, dat);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] q0, input logic [4:0] q1);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, q0, q1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_we = 1'b0;
    in_rd_a = 5'd0; in_rd_d = 32'd0; q_rs_a = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check_val("rst_rf_e", 64'(rf_rd_e), 64'd0);
    check_val("rst_rf_a", 64'(rf_rd_a), 64'd0);
    check_val("rst_rf_i", 64'(rf_rd_i), 64'd0);
    check_val("rst_hit", 64'(q_hit), 64'd0);
    check_val("rst_qd", 64'(q_d), 64'd0);
    check_val("rst_occ", 64'(occ), 64'd0);

    // Single write emerges DEPTH cycles later, exactly once.
    writes = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h11, 5'd5, 5'd0);
    idle(4, 5'd5, 5'd0);
    check_val("single_writes", 64'(writes), 64'd1);

    // Youngest of two writes to x7 wins; unrelated register misses.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hA, 5'd7, 5'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hB, 5'd7, 5'd8);
    idle(4, 5'd7, 5'd8);

    // x0 writes are dropped and x0 never hits.
    writes = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
    idle(4, 5'd0, 5'd0);
    check_val("x0_writes", 64'(writes), 64'd0);

    // Two stall cycles delay the write by two; still forwardable meanwhile.
    writes = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h66, 5'd6, 5'd6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd6);
    idle(4, 5'd6, 5'd6);
    check_val("stall_writes", 64'(writes), 64'd1);

    // Flush during stall: held stage 0 is cleared, incoming dropped.
    writes = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    check_val("flush_stall_occ", 64'(occ), 64'd0);
    idle(4, 5'd3, 5'd4);
    check_val("flush_stall_writes", 64'(writes), 64'd0);

    // Flush without stall: incoming dropped, older entry already moved past stage 0.
    writes = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
    idle(4, 5'd3, 5'd4);
    check_val("flush_writes", 64'(writes), 64'd1);

    // Same-cycle lookup of the incoming result, with and without stall.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd9);
    step(1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h77, 5'd10, 5'd9);
    idle(4, 5'd9, 5'd10);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd, q0, q1;
      rd = 5'($urandom_range(0, 7));
      q0 = 5'($urandom_range(0, 7));
      q1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           rd, $urandom, q0, q1);
    end
    idle(4, 5'd1, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
